// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit BCD up/down counter with a compile-time terminal value.
//   The count runs 0..MAX_VAL. At either end it wraps (WRAP=1) or holds
//   (WRAP=0). A load is accepted only when it is a legal count; a rejected
//   load leaves the count alone and raises a one-cycle error pulse.
//
// Parameters
//   DIGITS   number of BCD digits (count width 4*DIGITS)
//   MAX_VAL  terminal value in decimal, must be < 10**DIGITS
//   WRAP     1 = wrap at the ends, 0 = saturate
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (beats load and ena)
//   ena        in   step one count this cycle
//   up         in   1 = increment, 0 = decrement
//   load       in   synchronous load strobe (beats ena)
//   load_data  in   BCD value to load, digit 0 in [3:0]
//   Qdata      out  registered BCD count, digit 0 in [3:0]
//   tc         out  combinational terminal count, high the cycle before a wrap/saturate
//   load_err   out  registered one-cycle pulse: the previous load was rejected
module bcd_updown_counter #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MAX_VAL = 9675,
  parameter bit          WRAP    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   Qdata,
  output logic                  tc,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned val);
    logic [W-1:0] res;
    int unsigned  v;
    res = '0;
    v   = val;
    for (int i = 0; i < int'(DIGITS); i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] a);
    logic [W-1:0] res;
    logic         carry;
    res   = a;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (a[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = a[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] a);
    logic [W-1:0] res;
    logic         borrow;
    res    = a;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (a[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = a[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] a);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  logic [W-1:0] r_q;
  logic         r_load_err;
  logic         w_at_max;
  logic         w_at_zero;
  logic         w_load_ok;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;

  assign w_at_max  = (r_q == MAX_BCD);
  assign w_at_zero = (r_q == '0);
  assign w_inc     = bcd_inc(r_q);
  assign w_dec     = bcd_dec(r_q);
  // Once every digit is 0..9, BCD words order the same as their decimal
  // values, so a plain unsigned compare against MAX_BCD is exact.
  assign w_load_ok = digits_ok(load_data) && (load_data <= MAX_BCD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) r_q        <= load_data;
        else           r_load_err <= 1'b1;
      end else if (ena) begin
        if (up) begin
          if (w_at_max) r_q <= WRAP ? '0 : MAX_BCD;
          else          r_q <= w_inc;
        end else begin
          if (w_at_zero) r_q <= WRAP ? MAX_BCD : '0;
          else           r_q <= w_dec;
        end
      end
    end
  end

  assign Qdata    = r_q;
  assign load_err = r_load_err;
  assign tc       = ena & ~load & ((up & w_at_max) | (~up & w_at_zero));

endmodule
